button_event_decoder: RTL and testbench

- Consumer end of the push-button debouncer interface: takes the debounced level DPB plus the SCEN/MCEN pulses and classifies presses into SHORT, DOUBLE and LONG events, with optional auto-REPEAT.
- Sits between each debouncer instance and the game/control FSMs.
- Events are delivered through a one-entry valid/ready output register, so a busy consumer never loses the pending event silently.

---
 rtl/btn_evt_pkg.sv | 21 ++
 rtl/button_event_decoder_if.sv | 17 +
 rtl/evt_out_reg.sv | 41 ++++
 rtl/button_event_decoder.sv | 124 ++++++++++++
 tb/tb_button_event_decoder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types and constants for the push-button event decoder.
// Contents: classifier state enum and the 2-bit event code values.
package btn_evt_pkg;

    localparam int unsigned EV_W   = 2;
    localparam int unsigned MCNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HOLD
    } btn_state_t;

    localparam logic [EV_W-1:0] EV_SHORT  = 2'b00;
    localparam logic [EV_W-1:0] EV_DOUBLE = 2'b01;
    localparam logic [EV_W-1:0] EV_LONG   = 2'b10;
    localparam logic [EV_W-1:0] EV_REPEAT = 2'b11;

endpackage

// File: rtl/button_event_decoder_if.sv
// Event delivery channel: one-entry valid/ready with a sticky overflow flag.
//   ev_valid    : event pending (producer -> consumer)
//   ev_code     : event code (producer -> consumer)
//   ev_overflow : sticky, an event was dropped while one was pending
//   ev_ready    : consumer accepts when ev_valid && ev_ready
interface button_event_decoder_if;
    import btn_evt_pkg::*;

    logic            ev_valid;
    logic [EV_W-1:0] ev_code;
    logic            ev_overflow;
    logic            ev_ready;

    modport master (output ev_valid, ev_code, ev_overflow, input ev_ready);
    modport slave  (input ev_valid, ev_code, ev_overflow, output ev_ready);

endinterface

// File: rtl/evt_out_reg.sv
// One-entry valid/ready event register with sticky overflow flag.
// Ports:
//   clk, reset    : clock, synchronous active-low reset
//   push          : producer offers an event this cycle
//   push_code     : code of the offered event
//   ev_ready      : consumer accepts the pending event
//   ev_valid      : event pending
//   ev_code       : pending event code
//   ev_overflow   : sticky, set when an event arrives while one is held
module evt_out_reg #(
    parameter int unsigned CODE_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [CODE_W-1:0] push_code,
    input  logic              ev_ready,
    output logic              ev_valid,
    output logic [CODE_W-1:0] ev_code,
    output logic              ev_overflow
);

    // An arriving event may replace the entry only if it is empty or leaving now.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ev_valid    <= 1'b0;
            ev_code     <= '0;
            ev_overflow <= 1'b0;
        end else if (push) begin
            if (!ev_valid || ev_ready) begin
                ev_valid <= 1'b1;
                ev_code  <= push_code;
            end else begin
                ev_overflow <= 1'b1;
            end
        end else if (ev_valid && ev_ready) begin
            ev_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into SHORT / DOUBLE / LONG events.
// Optional feature: define REPEAT_EN to emit REPEAT on every MCEN while held
// after LONG; otherwise that logic is not built and code 11 never appears.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   DPB        : debounced button level
//   SCEN       : one pulse per press
//   MCEN       : pulse coincident with SCEN, then repeating while held
//   evt        : event channel (valid/code/overflow out, ready in)
module button_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int unsigned DBL_WIN   = 25_000_000,
    parameter int unsigned LONG_MCEN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   DPB,
    input  logic                   SCEN,
    input  logic                   MCEN,
    button_event_decoder_if.master evt
);

    localparam int unsigned WCNT_W = $clog2(DBL_WIN + 1);

    btn_state_t        state, state_nxt;
    logic [MCNT_W-1:0] mcnt, mcnt_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              push_c;
    logic [EV_W-1:0]   code_c;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            mcnt  <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            mcnt  <= mcnt_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Press classifier: next state, counters and event offer.
    always_comb begin
        state_nxt = state;
        mcnt_nxt  = mcnt;
        wcnt_nxt  = wcnt;
        push_c    = 1'b0;
        code_c    = EV_SHORT;
        unique case (state)
            IDLE: begin
                if (SCEN) begin
                    mcnt_nxt  = MCNT_W'(1);
                    state_nxt = PRESS1;
                end
            end
            PRESS1: begin
                if (MCEN && !SCEN && mcnt != MCNT_W'(LONG_MCEN)) begin
                    mcnt_nxt = mcnt + MCNT_W'(1);
                end
                // Reaching the threshold takes priority over a same-cycle release.
                if (mcnt_nxt == MCNT_W'(LONG_MCEN)) begin
                    push_c    = 1'b1;
                    code_c    = EV_LONG;
                    state_nxt = HOLD;
                end else if (!DPB) begin
                    wcnt_nxt  = '0;
                    state_nxt = WAIT2;
                end
            end
            WAIT2: begin
                wcnt_nxt = wcnt + WCNT_W'(1);
                // Timeout wins over a coincident SCEN; that press is still tracked.
                if (wcnt == WCNT_W'(DBL_WIN)) begin
                    push_c = 1'b1;
                    code_c = EV_SHORT;
                    if (SCEN) begin
                        mcnt_nxt  = MCNT_W'(1);
                        state_nxt = PRESS1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (SCEN) begin
                    push_c    = 1'b1;
                    code_c    = EV_DOUBLE;
                    state_nxt = PRESS2;
                end
            end
            PRESS2: begin
                if (!DPB) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
`ifdef REPEAT_EN
                if (MCEN) begin
                    push_c = 1'b1;
                    code_c = EV_REPEAT;
                end
`endif
                if (!DPB) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    evt_out_reg #(
        .CODE_W (EV_W)
    ) u_out (
        .clk         (clk),
        .reset       (reset),
        .push        (push_c),
        .push_code   (code_c),
        .ev_ready    (evt.ev_ready),
        .ev_valid    (evt.ev_valid),
        .ev_code     (evt.ev_code),
        .ev_overflow (evt.ev_overflow)
    );

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: directed steps followed by
// randomized press sequences checked against an event-timeline model.
module tb_button_event_decoder;

    localparam int DBL    = 100;
    localparam int LNG    = 4;
    localparam int MAXC   = 16384;
    localparam int NPRESS = 40;

    localparam logic [1:0] C_SHORT  = 2'b00;
    localparam logic [1:0] C_DOUBLE = 2'b01;
    localparam logic [1:0] C_LONG   = 2'b10;
    localparam logic [1:0] C_REPEAT = 2'b11;

    logic clk = 1'b0;
    logic reset;
    logic dpb, scen, mcen;

    int n_cmp = 0;
    int n_bad = 0;

    bit         a_dpb  [MAXC];
    bit         a_scen [MAXC];
    bit         a_mcen [MAXC];
    logic [1:0] exp_code [int];

    button_event_decoder_if evt ();

    button_event_decoder #(
        .DBL_WIN   (DBL),
        .LONG_MCEN (LNG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .DPB   (dpb),
        .SCEN  (scen),
        .MCEN  (mcen),
        .evt   (evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        assert (got === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge that used them.
    task automatic cyc(input logic d, input logic s, input logic m);
        dpb  = d;
        scen = s;
        mcen = m;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic watch(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (evt.ev_valid) seen++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int t, p, r, k, s, h, j, last;
        bit await_dbl, second;

        // Reset
        reset = 1'b0;
        evt.ev_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        chk("reset_valid", evt.ev_valid, 0);
        chk("reset_code", evt.ev_code, 0);
        chk("reset_ovf", evt.ev_overflow, 0);

        // Single press, two MCEN, timeout SHORT
        cyc(1, 1, 1); cyc(1, 0, 0); cyc(1, 0, 1); cyc(1, 0, 0);
        cyc(0, 0, 0);
        idle(DBL);
        chk("single_early", evt.ev_valid, 0);
        cyc(0, 0, 0);
        chk("single_valid", evt.ev_valid, 1);
        chk("single_code", evt.ev_code, C_SHORT);
        cyc(0, 0, 0);
        chk("single_clear", evt.ev_valid, 0);

        // Double click 40 cycles after release
        cyc(1, 1, 1); cyc(1, 0, 0);
        cyc(0, 0, 0);
        idle(39);
        chk("double_early", evt.ev_valid, 0);
        cyc(1, 1, 1);
        chk("double_valid", evt.ev_valid, 1);
        chk("double_code", evt.ev_code, C_DOUBLE);
        cyc(1, 0, 0);
        chk("double_clear", evt.ev_valid, 0);
        cyc(0, 0, 0);
        watch(DBL + 10, seen);
        chk("double_no_more", seen, 0);

        // Long hold
        cyc(1, 1, 1);
        repeat (3) begin cyc(1, 0, 0); cyc(1, 0, 1); end
        chk("long_valid", evt.ev_valid, 1);
        chk("long_code", evt.ev_code, C_LONG);
`ifdef REPEAT_EN
        repeat (3) begin
            cyc(1, 0, 0); cyc(1, 0, 1);
            chk("repeat_valid", evt.ev_valid, 1);
            chk("repeat_code", evt.ev_code, C_REPEAT);
        end
`else
        repeat (3) begin
            cyc(1, 0, 0); cyc(1, 0, 1);
            chk("hold_no_repeat", evt.ev_valid, 0);
        end
`endif
        cyc(0, 0, 0);
        watch(DBL + 10, seen);
        chk("long_no_release_ev", seen, 0);

        // SCEN exactly at the window boundary
        cyc(1, 1, 1);
        cyc(0, 0, 0);
        idle(DBL);
        cyc(1, 1, 1);
        chk("bound_valid", evt.ev_valid, 1);
        chk("bound_code", evt.ev_code, C_SHORT);
        cyc(0, 0, 0);
        chk("bound_clear", evt.ev_valid, 0);
        idle(DBL);
        chk("bound2_early", evt.ev_valid, 0);
        cyc(0, 0, 0);
        chk("bound2_valid", evt.ev_valid, 1);
        chk("bound2_code", evt.ev_code, C_SHORT);
        cyc(0, 0, 0);

        // Backpressure: SHORT held, DOUBLE overflows
        evt.ev_ready = 1'b0;
        cyc(1, 1, 1);
        cyc(0, 0, 0);
        idle(DBL);
        cyc(0, 0, 0);
        chk("bp_short_valid", evt.ev_valid, 1);
        chk("bp_short_ovf", evt.ev_overflow, 0);
        cyc(1, 1, 1);
        cyc(0, 0, 0);
        idle(5);
        cyc(1, 1, 1);
        chk("bp_ovf_set", evt.ev_overflow, 1);
        chk("bp_code_kept", evt.ev_code, C_SHORT);
        chk("bp_valid_kept", evt.ev_valid, 1);
        cyc(0, 0, 0);
        evt.ev_ready = 1'b1;
        cyc(0, 0, 0);
        chk("bp_accept_clear", evt.ev_valid, 0);
        chk("bp_ovf_sticky", evt.ev_overflow, 1);
        idle(20);
        chk("bp_ovf_sticky2", evt.ev_overflow, 1);

        // Reset during WAIT2 after a LONG leaves code 10 in the register
        cyc(1, 1, 1);
        repeat (3) begin cyc(1, 0, 0); cyc(1, 0, 1); end
        chk("pre_rst_code", evt.ev_code, C_LONG);
        cyc(0, 0, 0);
        cyc(1, 1, 1);
        cyc(0, 0, 0);
        idle(10);
        reset = 1'b0;
        cyc(0, 0, 0);
        chk("rst_valid", evt.ev_valid, 0);
        chk("rst_code", evt.ev_code, 0);
        chk("rst_ovf", evt.ev_overflow, 0);
        reset = 1'b1;
        watch(DBL + 30, seen);
        chk("rst_no_short", seen, 0);

        // Random press sequences: build input timeline and expected event edges
        t = 0;
        second = 0;
        for (int n = 0; n < NPRESS; n++) begin
            k = int'($urandom_range(1, LNG + 2));
            s = int'($urandom_range(2, 5));
            h = int'($urandom_range(1, s - 1));
            p = t;
            r = p + (k - 1) * s + h;
            for (int c = p; c < r; c++) a_dpb[c] = 1'b1;
            a_scen[p] = 1'b1;
            for (int i = 0; i < k; i++) a_mcen[p + i * s] = 1'b1;
            await_dbl = 1'b0;
            if (second) begin
                second = 1'b0;
            end else if (k >= LNG) begin
                exp_code[p + (LNG - 1) * s] = C_LONG;
`ifdef REPEAT_EN
                for (int i = LNG; i < k; i++) exp_code[p + i * s] = C_REPEAT;
`endif
            end else begin
                await_dbl = 1'b1;
            end
            case ($urandom_range(0, 3))
                0:       j = DBL - 1;
                1:       j = DBL;
                2:       j = DBL + 1;
                default: j = int'($urandom_range(0, DBL + 20));
            endcase
            if (n == NPRESS - 1) j = DBL + 10;
            if (await_dbl) begin
                if (j < DBL) begin
                    exp_code[r + 1 + j] = C_DOUBLE;
                    second = 1'b1;
                end else begin
                    exp_code[r + 1 + DBL] = C_SHORT;
                end
            end
            t = r + 1 + j;
        end
        last = t;

        for (int e = 0; e < last; e++) begin
            cyc(a_dpb[e], a_scen[e], a_mcen[e]);
            chk($sformatf("rnd_valid@%0d", e), evt.ev_valid, exp_code.exists(e));
            if (exp_code.exists(e))
                chk($sformatf("rnd_code@%0d", e), evt.ev_code, exp_code[e]);
        end
        chk("rnd_ovf", evt.ev_overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
